// File: rtl/uart_rx_if.sv
// Byte-output handshake between uart_rx and its consumer.
// The receiver drives data/valid and the error pulses; the consumer drives ready.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.master bus
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic          sync1, sync2;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic [7:0]    data_q, data_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          ovr_q, ovr_n;
`ifdef UART_RX_PARITY_EN
    logic          par_ok, par_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= 1'b1;
`endif
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
`ifdef UART_RX_PARITY_EN
            par_ok  <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = shreg;
        data_n  = data_q;
        // Consumption happens every cycle; a byte landing on the same edge reasserts valid below.
        valid_n = valid_q && !bus.ready;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_ok;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!sync2) begin
                    state_n = START;
                    bit_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {sync2, shreg[7:1]};
                    bit_n = bit_idx + 4'd1;
                    if (bit_idx == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    par_n   = ~(^shreg ^ sync2);
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (!sync2) begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (!par_ok) begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        state_n = IDLE;
                        if (valid_q && !bus.ready) begin
                            ovr_n = 1'b1;
                        end else begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (sync2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int ferr_seen = 0, ovr_seen = 0, vld_cycles = 0, last_vld_cyc = 0, e0 = 0;
    int v0, ferr_exp;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte, tallies error pulses.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.valid) begin
                vld_cycles++;
                last_vld_cyc = cyc;
            end
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, none expected", bus.data);
                end else begin
                    chk("rx_data", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.frame_err) ferr_seen++;
            if (bus.overrun) ovr_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic bad_par);
        e0 = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b ^ bad_par);
`endif
        send_bit(stop);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, {24'h0, bus.data}, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.valid}, 32'h0);
        chk({tag, "_frame_err"}, {31'h0, bus.frame_err}, 32'h0);
        chk({tag, "_overrun"}, {31'h0, bus.overrun}, 32'h0);
    endtask

    initial begin
        bus.ready = 1'b1;
        ferr_exp  = 0;
        tick(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick(5);

        // A5, ready high: one-cycle valid at the stop-sample edge
        v0 = vld_cycles;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        tick(4);
        chk("a5_latency", last_vld_cyc, e0 + 2 + H + (NB - 1) * CPB);
        chk("a5_valid_width", vld_cycles - v0, 1);

        // 4-clock glitch is a false start
        v0 = vld_cycles;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        chk("glitch_valid", vld_cycles - v0, 0);
        chk("glitch_frame_err", ferr_seen, 0);
        chk("glitch_overrun", ovr_seen, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0);
        tick(CPB);

        // Bad stop bit, line held low (break), then recovery
        v0 = vld_cycles;
        send_byte(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        tick(50 * CPB);
        ferr_exp++;
        chk("break_frame_err", ferr_seen, ferr_exp);
        chk("break_no_valid", vld_cycles - v0, 0);
        rx = 1'b1;
        tick(2 * CPB);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, 1'b0);
        tick(CPB);

        // Overrun: ready low, two back-to-back bytes
        bus.ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        tick(CPB);
        chk("ovr_count", ovr_seen, 1);
        chk("ovr_valid_held", {31'h0, bus.valid}, 32'h1);
        chk("ovr_data_held", {24'h0, bus.data}, 32'h11);
        bus.ready = 1'b1;
        tick(4);
        chk("ovr_drained", exp_q.size(), 0);
        chk("ovr_valid_cleared", {31'h0, bus.valid}, 32'h0);

        // Reset in the middle of data bit 4 of 99
        e0 = cyc + 1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        tick(H);
        rst_n = 1'b0;
        tick(2);
        chk_outputs_zero("midreset");
        rst_n = 1'b1;
        tick(2 * CPB);
        exp_q.push_back(8'h66);
        send_byte(8'h66, 1'b1, 1'b0);
        tick(CPB);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h03);
        send_byte(8'h03, 1'b1, 1'b0);
        tick(CPB);
        v0 = vld_cycles;
        send_byte(8'h03, 1'b1, 1'b1);
        tick(CPB);
        ferr_exp++;
        chk("parity_frame_err", ferr_seen, ferr_exp);
        chk("parity_no_valid", vld_cycles - v0, 0);
`endif

        tick(CPB);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_frame_err_total", ferr_seen, ferr_exp);
        chk("final_overrun_total", ovr_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
